mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit; sequences the shared datapath: PC, IR, register file, ALU, single unified memory port and immediate extender.
- Decodes the latched IR opcode/funct into per-state control strobes.
- Also selects sign- vs zero-extension for the 16-bit immediate.
- Handles a ready handshake on the memory port with an optional timeout.

Parameters:
- TIMEOUT_CYC, 15: max wait cycles for MEM_READY in a memory state; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- OPCODE  in  6  IR[31:26], stable outside FETCH
- FUNCT  in  6  IR[5:0] (informational; ALU decoder consumes it)
- ZERO  in  1  ALU zero flag
- MEM_READY  in  1  memory completes current access this cycle
- PC_EN  out  1  PC register load
- IORD  out  1  memory address: 0=PC, 1=ALUOut
- MEM_RD  out  1  memory read request
- MEM_WR  out  1  memory write request
- IR_WRITE  out  1  IR load
- REG_DST  out  1  write reg: 0=rt, 1=rd
- MEM_TO_REG  out  1  write data: 0=ALUOut, 1=MDR
- REG_WRITE  out  1  register file write enable
- ALU_SRC_A  out  1  0=PC, 1=regA
- ALU_SRC_B  out  2  00=regB, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALU_OP  out  2  00=add, 01=sub, 10=use FUNCT, 11=immediate logic by OPCODE
- PC_SRC  out  2  00=ALU result, 01=ALUOut, 10=jump target
- EXT_ZERO  out  1  extender mode: 1=zero-extend, 0=sign-extend
- ILLEGAL  out  1  one-cycle pulse on unsupported opcode
- MEM_ERR  out  1  one-cycle pulse on memory timeout
- STATE  out  4  current state code (debug)

Behaviour:
- Reset:
  - RESET=1 forces state to FETCH, wait counter to 0, STATE=0.
  - All other outputs are 0 while RESET=1, including gated combinational strobes.
  - First fetch begins on the first edge after deassertion.
  - Reset mid-instruction abandons it with no partial write.
- Outputs:
  - Moore decode of state; all strobes not listed for a state are 0.
  - Exceptions: PC_EN, IR_WRITE, ILLEGAL and MEM_ERR also depend on inputs, as stated per state below.
- FETCH (0): MEM_RD=1, IORD=0, SRC_A=0, SRC_B=01, ALU_OP=00, PC_SRC=00. IR_WRITE=PC_EN=MEM_READY. On MEM_READY go to DECODE, else stay.
- DECODE (1): SRC_A=0, SRC_B=11, ALU_OP=00 (branch target into ALUOut). Next state by OPCODE:
  - lw 100011 / sw 101011 -> MEMADR
  - R-type 000000 -> EXEC
  - beq 000100 / bne 000101 -> BRANCH
  - addi 001000, slti 001010, andi 001100, ori 001101 -> IMMEX
  - j 000010 -> JUMP
  - any other opcode -> FETCH with ILLEGAL=1 for that cycle
- MEMADR (2): SRC_A=1, SRC_B=10, ALU_OP=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): MEM_RD=1, IORD=1. On MEM_READY go to MEMWB.
- MEMWB (4): REG_WRITE=1, REG_DST=0, MEM_TO_REG=1. Then FETCH.
- MEMWR (5): MEM_WR=1, IORD=1. On MEM_READY go to FETCH.
- EXEC (6): SRC_A=1, SRC_B=00, ALU_OP=10. Then ALUWB.
- ALUWB (7): REG_WRITE=1, REG_DST=1. Then FETCH.
- BRANCH (8): SRC_A=1, SRC_B=00, ALU_OP=01, PC_SRC=01. PC_EN = ZERO XOR (OPCODE==bne). Then FETCH.
- IMMEX (9): SRC_A=1, SRC_B=10, ALU_OP = 00 for addi, 01 for slti-compare, 11 for andi/ori. EXT_ZERO=1 only for andi/ori. Then IMMWB.
- IMMWB (10): REG_WRITE=1, REG_DST=0, EXT_ZERO held as in IMMEX. Then FETCH.
- JUMP (11): PC_SRC=10, PC_EN=1. Then FETCH.
- Codes 12-15 are unreachable; if entered, next state is FETCH.
- EXT_ZERO is 0 in every state not listed above (sign-extend default).
- Latency in cycles with zero wait states:
  - R-type 4, lw 5, sw 4, immediate 4, beq/bne 3, j 3, illegal 2.
  - Each extra cycle of MEM_READY low adds one cycle.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle spent there with MEM_READY=0.
  - If TIMEOUT_CYC!=0 and the counter equals TIMEOUT_CYC with MEM_READY=0: MEM_ERR=1 for that cycle, no IR/PC/register write, next state FETCH.
  - MEM_READY=1 on the same cycle as the timeout wins: normal completion, no MEM_ERR.
- MEM_READY outside memory states is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J)
  - state enum ctrl_state_t (4 bits)
  - ALU_OP, ALU_SRC_B and PC_SRC encodings
- Sub-module: mips_mem_wait_timer (wait counter plus timeout compare).
- Next-state logic and output decode stay in mips_multicycle_ctrl.

Test Plan:
- Reset, then lw (0x8C...) with MEM_READY tied 1 -> states 0,1,2,3,4,0. REG_WRITE=1 and MEM_TO_REG=1 exactly in cycle 5. IR_WRITE=1 in cycle 1 only.
- R-type add, MEM_READY low for 3 fetch cycles -> FETCH held 4 cycles with MEM_RD=1 and IR_WRITE=0 until ready. REG_DST=1 and REG_WRITE=1 in ALUWB.
- beq with ZERO=1 -> PC_EN=1 and PC_SRC=01 in BRANCH. bne with ZERO=1 -> PC_EN=0. andi -> EXT_ZERO=1; addi -> EXT_ZERO=0.
- Opcode 0x3F -> ILLEGAL pulses 1 cycle in DECODE, next state FETCH, REG_WRITE never asserted.
- TIMEOUT_CYC=15, sw with MEM_READY held 0 -> MEM_ERR pulses on the 16th MEMWR cycle, return to FETCH. MEM_READY=1 on that same cycle -> no MEM_ERR.
- RESET asserted asynchronously mid-EXEC -> all outputs 0 immediately, STATE=0. After release, fetch resumes with MEM_RD=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice: opcodes,
// controller state codes and datapath mux/ALU encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } ctrl_state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that own the memory port and therefore wait on MEM_READY.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return s inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts cycles spent waiting for MEM_READY in a memory state and flags
// a timeout when the wait reaches TIMEOUT_CYC (0 disables the timeout).
module mips_mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i && !ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (TIMEOUT_CYC != 0) && active_i && !ready_i &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared
// datapath with a single memory port guarded by a ready handshake.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       PC_EN,
    output logic       IORD,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       IR_WRITE,
    output logic       REG_DST,
    output logic       MEM_TO_REG,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] ALU_OP,
    output logic [1:0] PC_SRC,
    output logic       EXT_ZERO,
    output logic       ILLEGAL,
    output logic       MEM_ERR,
    output logic [3:0] STATE
);

    ctrl_state_t state_q, state_d;
    logic        mem_timeout;
    logic        wait_clr;
    logic        op_legal;
    logic        imm_logic;

    // FUNCT is decoded by the ALU control, not here.
    logic unused_funct;
    assign unused_funct = ^FUNCT;

    assign op_legal  = OPCODE inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
                                      OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
    assign imm_logic = (OPCODE == OP_ANDI) || (OPCODE == OP_ORI);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MEM_READY) state_d = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_RTYPE:                          state_d = S_EXEC;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
                    OP_J:                              state_d = S_JUMP;
                    default:                           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (OPCODE == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  begin
                if (MEM_READY)        state_d = S_MEMWB;
                else if (mem_timeout) state_d = S_FETCH;
            end
            S_MEMWR:  if (MEM_READY || mem_timeout) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // A timeout in FETCH stays in FETCH, so it must restart the count explicitly.
    assign wait_clr = (state_d != state_q) || mem_timeout;

    mips_mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clear_i  (wait_clr),
        .active_i (is_mem_state(state_q)),
        .ready_i  (MEM_READY),
        .timeout_o(mem_timeout)
    );

    always_comb begin
        PC_EN      = 1'b0;
        IORD       = 1'b0;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        IR_WRITE   = 1'b0;
        REG_DST    = 1'b0;
        MEM_TO_REG = 1'b0;
        REG_WRITE  = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = SRCB_REG;
        ALU_OP     = ALU_OP_ADD;
        PC_SRC     = PCSRC_ALU;
        EXT_ZERO   = 1'b0;
        ILLEGAL    = 1'b0;
        MEM_ERR    = 1'b0;
        STATE      = state_q;
        if (!RESET) begin
            case (state_q)
                S_FETCH: begin
                    MEM_RD    = 1'b1;
                    ALU_SRC_B = SRCB_FOUR;
                    IR_WRITE  = MEM_READY;
                    PC_EN     = MEM_READY;
                    MEM_ERR   = mem_timeout;
                end
                S_DECODE: begin
                    ALU_SRC_B = SRCB_IMM_SH2;
                    ILLEGAL   = !op_legal;
                end
                S_MEMADR: begin
                    ALU_SRC_A = 1'b1;
                    ALU_SRC_B = SRCB_IMM;
                end
                S_MEMRD: begin
                    MEM_RD  = 1'b1;
                    IORD    = 1'b1;
                    MEM_ERR = mem_timeout;
                end
                S_MEMWB: begin
                    REG_WRITE  = 1'b1;
                    MEM_TO_REG = 1'b1;
                end
                S_MEMWR: begin
                    MEM_WR  = 1'b1;
                    IORD    = 1'b1;
                    MEM_ERR = mem_timeout;
                end
                S_EXEC: begin
                    ALU_SRC_A = 1'b1;
                    ALU_OP    = ALU_OP_FUNCT;
                end
                S_ALUWB: begin
                    REG_WRITE = 1'b1;
                    REG_DST   = 1'b1;
                end
                S_BRANCH: begin
                    ALU_SRC_A = 1'b1;
                    ALU_OP    = ALU_OP_SUB;
                    PC_SRC    = PCSRC_ALUOUT;
                    PC_EN     = ZERO ^ (OPCODE == OP_BNE);
                end
                S_IMMEX: begin
                    ALU_SRC_A = 1'b1;
                    ALU_SRC_B = SRCB_IMM;
                    ALU_OP    = (OPCODE == OP_ADDI) ? ALU_OP_ADD :
                                (OPCODE == OP_SLTI) ? ALU_OP_SUB : ALU_OP_IMM;
                    EXT_ZERO  = imm_logic;
                end
                S_IMMWB: begin
                    REG_WRITE = 1'b1;
                    EXT_ZERO  = imm_logic;
                end
                S_JUMP: begin
                    PC_SRC = PCSRC_JUMP;
                    PC_EN  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus
// randomized instruction streams against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b, alu_op, pc_src;
        logic       ext_zero, illegal, mem_err;
    } outs_t;

    typedef struct {
        int   st;
        logic rdy;
        logic err;
    } step_t;

    localparam int TMO = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] OPCODE = '0;
    logic [5:0] FUNCT = '0;
    logic       ZERO = 1'b0;
    logic       MEM_READY = 1'b0;
    logic       PC_EN, IORD, MEM_RD, MEM_WR, IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A;
    logic [1:0] ALU_SRC_B, ALU_OP, PC_SRC;
    logic       EXT_ZERO, ILLEGAL, MEM_ERR;
    logic [3:0] STATE;
    outs_t      obs;

    int checks = 0;
    int errors = 0;
    step_t trace[$];

    assign obs = {PC_EN, IORD, MEM_RD, MEM_WR, IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A,
                  ALU_SRC_B, ALU_OP, PC_SRC, EXT_ZERO, ILLEGAL, MEM_ERR};

    always #5 CLK = ~CLK;

    mips_multicycle_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .MEM_READY(MEM_READY), .PC_EN(PC_EN), .IORD(IORD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .IR_WRITE(IR_WRITE), .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .PC_SRC(PC_SRC),
        .EXT_ZERO(EXT_ZERO), .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR), .STATE(STATE)
    );

    // Per-state control table, as the datasheet lists it.
    function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic z,
                                      input logic rdy, input logic err);
        outs_t o = '0;
        case (st)
            0:  begin o.mem_rd = 1; o.src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; o.mem_err = err; end
            1:  begin o.src_b = 2'b11;
                      o.illegal = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                                               6'h0D, 6'h23, 6'h2B}); end
            2:  begin o.src_a = 1; o.src_b = 2'b10; end
            3:  begin o.mem_rd = 1; o.iord = 1; o.mem_err = err; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.mem_wr = 1; o.iord = 1; o.mem_err = err; end
            6:  begin o.src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z ^ (op == 6'h05); end
            9:  begin o.src_a = 1; o.src_b = 2'b10;
                      o.alu_op = (op == 6'h08) ? 2'b00 : (op == 6'h0A) ? 2'b01 : 2'b11;
                      o.ext_zero = (op == 6'h0C) || (op == 6'h0D); end
            10: begin o.reg_write = 1; o.ext_zero = (op == 6'h0C) || (op == 6'h0D); end
            11: begin o.pc_src = 2'b10; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // Memory access that sees `w` not-ready cycles before ready; returns 0 if it times out.
    function automatic bit mem_phase(input int st, input int w);
        for (int i = 0; ; i++) begin
            if (i == TMO && w > i) begin
                trace.push_back('{st, 1'b0, 1'b1});
                return 0;
            end
            if (i == w) begin
                trace.push_back('{st, 1'b1, 1'b0});
                return 1;
            end
            trace.push_back('{st, 1'b0, 1'b0});
        end
    endfunction

    function automatic void other(input int st);
        trace.push_back('{st, 1'($urandom), 1'b0});
    endfunction

    // Instruction-level reference: expected state path and handshake for one instruction.
    function automatic void model_instr(input logic [5:0] op, input int fw, input int mw);
        trace.delete();
        if (!mem_phase(0, fw)) return;
        other(1);
        case (op)
            6'h23: begin other(2); if (mem_phase(3, mw)) other(4); end
            6'h2B: begin other(2); void'(mem_phase(5, mw)); end
            6'h00: begin other(6); other(7); end
            6'h04, 6'h05: other(8);
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin other(9); other(10); end
            6'h02: other(11);
            default: ;
        endcase
    endfunction

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 11));
        if (r < 7) return 0;
        if (r < 9) return int'($urandom_range(1, 3));
        if (r == 9) return TMO;
        return int'($urandom_range(TMO + 1, TMO + 3));
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        #2;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; MEM_READY = 1'b1; OPCODE = 6'h23; ZERO = 1'b1;
        tick();
        checks++;
        if (obs !== outs_t'('0)) begin errors++; $display("FAIL reset_outs: got %h want 0", obs); end
        checks++;
        if (STATE !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", STATE); end
        RESET = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out(0, OPCODE, ZERO, 1'b1, 1'b0))
            begin errors++; $display("FAIL reset_release_fetch: got %h want %h", obs, exp_out(0, OPCODE, ZERO, 1'b1, 1'b0)); end
        tick();
        checks++;
        if (STATE !== 4'd1) begin errors++; $display("FAIL reset_first_fetch: state %0d want 1", STATE); end
    endtask

    task automatic test_lw();
        int exp_st[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        OPCODE = 6'h23; MEM_READY = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++;
            if (STATE !== 4'(exp_st[c-1])) begin errors++; $display("FAIL lw_state c%0d: got %0d want %0d", c, STATE, exp_st[c-1]); end
            if (c <= 5) begin
                checks++;
                if ({REG_WRITE, MEM_TO_REG, IR_WRITE} !== {c == 5, c == 5, c == 1})
                    begin errors++; $display("FAIL lw_strobes c%0d: got %b want %b", c, {REG_WRITE, MEM_TO_REG, IR_WRITE}, {c == 5, c == 5, c == 1}); end
            end
            tick();
        end
    endtask

    task automatic test_rtype_wait();
        int exp_st[7] = '{0, 0, 0, 0, 1, 6, 7};
        do_reset();
        OPCODE = 6'h00; FUNCT = 6'h20;
        for (int c = 0; c < 7; c++) begin
            MEM_READY = (c == 3) ? 1'b1 : 1'b0;
            #1;
            checks++;
            if (STATE !== 4'(exp_st[c])) begin errors++; $display("FAIL rtype_state c%0d: got %0d want %0d", c, STATE, exp_st[c]); end
            if (c < 4) begin
                checks++;
                if ({MEM_RD, IR_WRITE} !== {1'b1, c == 3}) begin errors++; $display("FAIL rtype_fetch c%0d: got %b want %b", c, {MEM_RD, IR_WRITE}, {1'b1, c == 3}); end
            end
            if (c == 6) begin
                checks++;
                if ({REG_DST, REG_WRITE} !== 2'b11) begin errors++; $display("FAIL rtype_aluwb: got %b want 11", {REG_DST, REG_WRITE}); end
            end
            tick();
        end
    endtask

    task automatic test_branch_imm();
        logic [5:0] ops[4] = '{6'h04, 6'h05, 6'h0C, 6'h08};
        logic [4:0] want[4] = '{5'b1_01_0_0, 5'b0_01_0_0, 5'b0_00_1_1, 5'b0_00_0_0};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            OPCODE = ops[k]; ZERO = 1'b1; MEM_READY = 1'b1;
            tick(); tick();
            #1;
            // {PC_EN, PC_SRC, EXT_ZERO in exec, EXT_ZERO in writeback}
            checks++;
            if ({PC_EN, PC_SRC, EXT_ZERO} !== want[k][4:1])
                begin errors++; $display("FAIL branch_imm op%h: got %b want %b", ops[k], {PC_EN, PC_SRC, EXT_ZERO}, want[k][4:1]); end
            tick();
            if (ops[k] inside {6'h0C, 6'h08}) begin
                checks++;
                if ({STATE, EXT_ZERO} !== {4'd10, want[k][0]})
                    begin errors++; $display("FAIL imm_wb op%h: got %b want %b", ops[k], {STATE, EXT_ZERO}, {4'd10, want[k][0]}); end
            end
        end
        ZERO = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        OPCODE = 6'h3F; MEM_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({STATE, ILLEGAL, REG_WRITE} !== {4'(c % 2), c == 1, 1'b0})
                begin errors++; $display("FAIL illegal c%0d: got %b want %b", c, {STATE, ILLEGAL, REG_WRITE}, {4'(c % 2), c == 1, 1'b0}); end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            OPCODE = 6'h2B; MEM_READY = 1'b1;
            tick(); tick(); tick();
            for (int k = 1; k <= TMO + 1; k++) begin
                MEM_READY = (v == 1 && k == TMO + 1);
                #1;
                checks++;
                if ({STATE, MEM_ERR} !== {4'd5, v == 0 && k == TMO + 1})
                    begin errors++; $display("FAIL timeout v%0d k%0d: got %b want %b", v, k, {STATE, MEM_ERR}, {4'd5, v == 0 && k == TMO + 1}); end
                tick();
            end
            MEM_READY = 1'b0;
            #1;
            checks++;
            if ({STATE, MEM_ERR} !== 5'b0) begin errors++; $display("FAIL timeout_return v%0d: got %b want 0", v, {STATE, MEM_ERR}); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        OPCODE = 6'h00; MEM_READY = 1'b1;
        tick(); tick();
        checks++;
        if (STATE !== 4'd6) begin errors++; $display("FAIL async_pre: state %0d want 6", STATE); end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({obs, STATE} !== '0) begin errors++; $display("FAIL async_reset: outs %h state %0d want 0", obs, STATE); end
        tick();
        RESET = 1'b0;
        #1;
        checks++;
        if ({STATE, MEM_RD} !== {4'd0, 1'b1}) begin errors++; $display("FAIL async_resume: state %0d mem_rd %b", STATE, MEM_RD); end
        tick();
        checks++;
        if (STATE !== 4'd1) begin errors++; $display("FAIL async_decode: state %0d want 1", STATE); end
    endtask

    task automatic test_random();
        logic [5:0] pool[12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                                 6'h23, 6'h2B, 6'h3F, 6'h11};
        outs_t e;
        do_reset();
        for (int n = 0; n < 250; n++) begin
            OPCODE = pool[$urandom_range(0, 11)];
            ZERO = 1'($urandom);
            FUNCT = 6'($urandom);
            model_instr(OPCODE, (n % 4 == 0) ? pick_wait() : 0, pick_wait());
            foreach (trace[i]) begin
                MEM_READY = trace[i].rdy;
                #1;
                e = exp_out(trace[i].st, OPCODE, ZERO, trace[i].rdy, trace[i].err);
                checks++;
                if (STATE !== 4'(trace[i].st))
                    begin errors++; $display("FAIL rand_state n%0d op%h: got %0d want %0d", n, OPCODE, STATE, trace[i].st); end
                checks++;
                if (obs !== e)
                    begin errors++; $display("FAIL rand_outs n%0d op%h st%0d: got %h want %h", n, OPCODE, trace[i].st, obs, e); end
                tick();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_lw();
        test_rtype_wait();
        test_branch_imm();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
